// File: rtl/mpls_pkg.sv
// mpls_pkg: shared state encoding, pattern constants and playlist entry type for the scheduler
package mpls_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, MANUAL} state_t;
    localparam int PAT_W = 5;
    localparam logic [PAT_W-1:0] PAT_OFF = 5'd0;
    localparam logic [PAT_W-1:0] PAT_DEMO = 5'd31;
    localparam int ENT_DWELL_W = 8;
    typedef struct packed {
        logic [PAT_W-1:0]       pattern;
        logic [ENT_DWELL_W-1:0] dwell;
    } entry_t;
endpackage

// File: rtl/mpls_tick_div.sv
// mpls_tick_div: dwell-tick prescaler, one tick every reload+1 enabled cycles
module mpls_tick_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk_pll,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    // tick is flagged while the counter sits on its terminal count
    always_comb tick = en && cnt == reload;
    // count 0..reload while enabled, restart on clear, hold otherwise
    always_ff @(posedge clk_pll or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/mpls_playlist_sched.sv
// mpls_playlist_sched: plays a (pattern, dwell) playlist into the pattern generator select with manual override
module mpls_playlist_sched
    import mpls_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IDX_W = 3,
    parameter int DIV_W = 8,
    parameter int DWELL_W = 8
) (
    input  logic               clk_pll,
    input  logic               rst,
    input  logic [DIV_W-1:0]   tick_div,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [PAT_W-1:0]   wr_pattern,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic [IDX_W:0]     list_len,
    input  logic               start,
    input  logic               stop,
    input  logic               manual_req,
    input  logic [PAT_W-1:0]   manual_sel,
    output logic [PAT_W-1:0]   pattern_sel,
    output logic [IDX_W-1:0]   entry_idx,
    output logic               playing,
    output logic               manual_gnt,
    output logic               sel_change
);
    localparam logic [IDX_W:0] MAX_LEN = (IDX_W+1)'(ENTRIES);

    entry_t             slots [ENTRIES];
    state_t             state, nxt_state;
    logic [DWELL_W-1:0] dwell_cnt, nxt_dwell;
    logic [PAT_W-1:0]   nxt_pat;
    logic [IDX_W:0]     eff_len, inc;
    logic [IDX_W-1:0]   adv_idx, load_idx;
    logic               has_list, load, tick;

    mpls_tick_div #(.DIV_W(DIV_W)) u_tick (
        .clk_pll (clk_pll),
        .rst     (rst),
        .clr     (load),
        .en      (state == PLAY),
        .reload  (tick_div),
        .tick    (tick)
    );

    // clamp the list length and work out the slot that follows the current one
    always_comb begin
        eff_len  = list_len > MAX_LEN ? MAX_LEN : list_len;
        has_list = eff_len != '0;
        inc      = {1'b0, entry_idx} + 1'b1;
        adv_idx  = inc >= eff_len ? '0 : inc[IDX_W-1:0];
    end

    // next-state decision, priority stop > start > manual_req > tick; a load reads the pre-write table
    always_comb begin
        nxt_state = state;
        nxt_pat   = pattern_sel;
        nxt_dwell = dwell_cnt;
        load      = 1'b0;
        load_idx  = entry_idx;
        if (stop) begin
            nxt_state = IDLE;
            nxt_pat   = PAT_OFF;
        end else if (start && has_list && !(state == MANUAL && manual_req)) begin
            load     = 1'b1;
            load_idx = '0;
        end else if (state == MANUAL) begin
            if (manual_req) nxt_pat = manual_sel;
            else load = 1'b1;
        end else if (state == PLAY) begin
            if (manual_req) begin
                nxt_state = MANUAL;
                nxt_pat   = manual_sel;
            end else if (tick && !has_list) begin
                nxt_state = IDLE;
                nxt_pat   = PAT_OFF;
            end else if (tick && dwell_cnt != '0) begin
                nxt_dwell = dwell_cnt - 1'b1;
            end else if (tick) begin
                load     = 1'b1;
                load_idx = adv_idx;
            end
        end
        if (load) begin
            nxt_state = PLAY;
            nxt_pat   = slots[load_idx].pattern;
            nxt_dwell = DWELL_W'(slots[load_idx].dwell);
        end
    end

    // playlist table, writable in any state
    always_ff @(posedge clk_pll or posedge rst)
        if (rst) for (int i = 0; i < ENTRIES; i++) slots[i] <= '0;
        else if (wr_en) slots[wr_addr] <= '{pattern: wr_pattern, dwell: ENT_DWELL_W'(wr_dwell)};

    // scheduler state and registered outputs
    always_ff @(posedge clk_pll or posedge rst)
        if (rst) begin
            state       <= IDLE;
            pattern_sel <= PAT_OFF;
            entry_idx   <= '0;
            dwell_cnt   <= '0;
            playing     <= 1'b0;
            manual_gnt  <= 1'b0;
            sel_change  <= 1'b0;
        end else begin
            state       <= nxt_state;
            pattern_sel <= nxt_pat;
            entry_idx   <= load ? load_idx : entry_idx;
            dwell_cnt   <= nxt_dwell;
            playing     <= nxt_state != IDLE;
            manual_gnt  <= nxt_state == MANUAL;
            sel_change  <= nxt_pat != pattern_sel;
        end
endmodule

// File: tb/tb_mpls_playlist_sched.sv
// tb_mpls_playlist_sched: directed scenarios plus random traffic against a cycle-count playlist model
module tb_mpls_playlist_sched;
    logic       clk_pll = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tick_div = 8'd3;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [4:0] wr_pattern = '0;
    logic [7:0] wr_dwell = '0;
    logic [3:0] list_len = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       manual_req = 1'b0;
    logic [4:0] manual_sel = '0;
    logic [4:0] pattern_sel;
    logic [2:0] entry_idx;
    logic       playing, manual_gnt, sel_change;

    int checks = 0, failures = 0, pulses = 0;
    // model: 0 idle, 1 play, 2 manual; age = cycles shown since the entry was loaded
    int m_st, m_idx, m_pat, m_chg, m_age, m_dw;
    int t_pat [8];
    int t_dw [8];

    mpls_playlist_sched dut (
        .clk_pll     (clk_pll),
        .rst         (rst),
        .tick_div    (tick_div),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_pattern  (wr_pattern),
        .wr_dwell    (wr_dwell),
        .list_len    (list_len),
        .start       (start),
        .stop        (stop),
        .manual_req  (manual_req),
        .manual_sel  (manual_sel),
        .pattern_sel (pattern_sel),
        .entry_idx   (entry_idx),
        .playing     (playing),
        .manual_gnt  (manual_gnt),
        .sel_change  (sel_change)
    );

    always #5 clk_pll = ~clk_pll;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_idx = 0; m_pat = 0; m_chg = 0; m_age = 0; m_dw = 0;
        for (int i = 0; i < 8; i++) begin
            t_pat[i] = 0;
            t_dw[i] = 0;
        end
    endtask

    // an entry shows (dwell+1)*(tick_div+1) cycles; ticks fall on every (tick_div+1)th cycle of it
    task automatic model_step();
        int len, ld, old, per;
        bit tk, done;
        len  = list_len > 8 ? 8 : int'(list_len);
        per  = int'(tick_div) + 1;
        old  = m_pat;
        ld   = -1;
        tk   = m_st == 1 && (m_age + 1) % per == 0;
        done = m_st == 1 && m_age + 1 == (m_dw + 1) * per;
        if (stop) begin
            m_st = 0; m_pat = 0;
        end else if (start && len != 0 && !(m_st == 2 && manual_req)) begin
            ld = 0;
        end else if (m_st == 2) begin
            if (manual_req) m_pat = int'(manual_sel);
            else ld = m_idx;
        end else if (m_st == 1) begin
            if (manual_req) begin
                m_st = 2; m_pat = int'(manual_sel);
            end else if (tk && len == 0) begin
                m_st = 0; m_pat = 0;
            end else if (done) begin
                ld = (m_idx + 1 >= len) ? 0 : m_idx + 1;
            end else begin
                m_age++;
            end
        end
        if (ld >= 0) begin
            m_st = 1; m_idx = ld; m_pat = t_pat[ld]; m_dw = t_dw[ld]; m_age = 0;
        end
        if (wr_en) begin
            t_pat[wr_addr] = int'(wr_pattern);
            t_dw[wr_addr] = int'(wr_dwell);
        end
        m_chg = m_pat != old ? 1 : 0;
    endtask

    task automatic step();
        @(posedge clk_pll);
        model_step();
        #1;
        chk("pattern_sel", 32'(pattern_sel), m_pat);
        chk("playing", 32'(playing), 32'(m_st != 0));
        chk("manual_gnt", 32'(manual_gnt), 32'(m_st == 2));
        chk("sel_change", 32'(sel_change), m_chg);
        if (m_st != 0) chk("entry_idx", 32'(entry_idx), m_idx);
        pulses += int'(sel_change);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input int a, input int p, input int d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_pattern = 5'(p); wr_dwell = 8'(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk_pll);
        #1;
        chk("rst_pattern", 32'(pattern_sel), 0);
        chk("rst_idx", 32'(entry_idx), 0);
        chk("rst_playing", 32'(playing), 0);
        chk("rst_gnt", 32'(manual_gnt), 0);
        chk("rst_change", 32'(sel_change), 0);
        rst = 1'b0;

        wr(0, 3, 1); wr(1, 11, 0); wr(2, 27, 2);
        list_len = 4'd3;
        pulses = 0;
        pulse_start();
        chk("t1_first", 32'(pattern_sel), 3);
        run(7);  chk("t1_p3_hold", 32'(pattern_sel), 3);
        run(1);  chk("t1_p11", 32'(pattern_sel), 11);
        run(3);  chk("t1_p11_hold", 32'(pattern_sel), 11);
        run(1);  chk("t1_p27", 32'(pattern_sel), 27);
        run(11); chk("t1_p27_hold", 32'(pattern_sel), 27);
        run(1);  chk("t1_wrap", 32'(pattern_sel), 3);
        chk("t1_pulses", pulses, 4);

        run(8);  chk("t2_slot1", 32'(entry_idx), 1);
        run(1);
        manual_req = 1'b1; manual_sel = 5'd16;
        step();
        chk("t2_gnt", 32'(manual_gnt), 1);
        chk("t2_manual_pat", 32'(pattern_sel), 16);
        run(5);  chk("t2_idx_frozen", 32'(entry_idx), 1);
        manual_sel = 5'd31;
        step();  chk("t2_demo_pass", 32'(pattern_sel), 31);
        manual_req = 1'b0;
        step();
        chk("t2_resume", 32'(pattern_sel), 11);
        chk("t2_gnt_off", 32'(manual_gnt), 0);
        run(3);  chk("t2_full_dwell", 32'(pattern_sel), 11);
        run(1);  chk("t2_next", 32'(pattern_sel), 27);

        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("t3_stop_pat", 32'(pattern_sel), 0);
        chk("t3_stop_playing", 32'(playing), 0);
        list_len = 4'd0;
        pulse_start();
        chk("t3_empty_start", 32'(playing), 0);
        run(3);

        wr(3, 5, 0);
        list_len = 4'd4;
        pulse_start();
        run(8);  chk("t4_idx1", 32'(entry_idx), 1);
        run(4);  chk("t4_idx2", 32'(entry_idx), 2);
        list_len = 4'd2;
        run(11); chk("t4_idx2_hold", 32'(entry_idx), 2);
        run(1);  chk("t4_shrink_wrap", 32'(entry_idx), 0);
        list_len = 4'd12;
        run(28); chk("t4_clamp_idx4", 32'(entry_idx), 4);
        run(16); chk("t4_clamp_wrap", 32'(entry_idx), 0);

        stop = 1'b1; step(); stop = 1'b0;
        list_len = 4'd1;
        start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_pattern = 5'd9; wr_dwell = 8'd0;
        step();
        start = 1'b0; wr_en = 1'b0;
        chk("t5_old_pat", 32'(pattern_sel), 3);
        run(7);  chk("t5_old_dwell", 32'(pattern_sel), 3);
        run(1);  chk("t5_new_pat", 32'(pattern_sel), 9);
        pulses = 0;
        run(4);
        chk("t5_same_reload", 32'(pattern_sel), 9);
        chk("t5_no_pulse", pulses, 0);

        run(2);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_pat", 32'(pattern_sel), 0);
        chk("t6_async_playing", 32'(playing), 0);
        chk("t6_async_idx", 32'(entry_idx), 0);
        model_reset();
        @(posedge clk_pll);
        #1 rst = 1'b0;
        list_len = 4'd1;
        pulse_start();
        chk("t6_cleared_pat", 32'(pattern_sel), 0);
        chk("t6_no_change", 32'(sel_change), 0);
        chk("t6_playing", 32'(playing), 1);

        tick_div = 8'd1;
        for (int i = 0; i < 3000; i++) begin
            start = $urandom_range(0, 39) == 0;
            stop = $urandom_range(0, 79) == 0;
            if ($urandom_range(0, 15) == 0) manual_req = ~manual_req;
            manual_sel = 5'($urandom_range(0, 31));
            wr_en = $urandom_range(0, 3) == 0;
            wr_addr = 3'($urandom_range(0, 7));
            wr_pattern = 5'($urandom_range(0, 31));
            wr_dwell = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) list_len = 4'($urandom_range(0, 12));
            if (m_st == 0 && $urandom_range(0, 9) == 0) tick_div = 8'($urandom_range(0, 3));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
